// File: rtl/ecc_sed_pkg.sv
// Shared SED parity definitions for the encoder and decoder: widths, parity helper, output buffer states.
package ecc_sed_pkg;

  localparam int SED_DATA_WIDTH = 12;
  localparam int SED_CW_WIDTH   = SED_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Zero-extending a narrower codeword into this argument leaves the XOR unchanged,
  // so one helper serves any codeword width up to 64 bits.
  function automatic logic sed_parity(input logic [63:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/ecc_sed_decoder_if.sv
// Codeword-in / payload-out valid-ready bundle; master drives codewords and consumes payloads.
interface ecc_sed_decoder_if
  import ecc_sed_pkg::*;
#(
  parameter int DATA_WIDTH = SED_DATA_WIDTH
);

  logic                  enc_valid;
  logic                  enc_ready;
  logic [DATA_WIDTH:0]   enc_codeword;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_error;

  modport master (
    output enc_valid, enc_codeword, dec_ready,
    input  enc_ready, dec_valid, dec_data, dec_error
  );

  modport slave (
    input  enc_valid, enc_codeword, dec_ready,
    output enc_ready, dec_valid, dec_data, dec_error
  );

endinterface

// File: rtl/ecc_sed_skid_buf.sv
// Two-entry valid/ready buffer: 1-cycle latency, full throughput; wr_ready depends on state only,
// so the second slot absorbs the word already in flight when the consumer stalls.
module ecc_sed_skid_buf
  import ecc_sed_pkg::*;
#(
  parameter int WIDTH = SED_CW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  buf_state_t       state;
  buf_state_t       state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             pop;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    wr_ready = (state != FULL);
    rd_valid = (state != EMPTY);
  end

  // The output register only changes when empty, popping, or draining the skid slot,
  // which keeps rd_data stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data   <= '0;
      skid_data <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) rd_data <= wr_data;
        ONE: begin
          if (push && pop)  rd_data   <= wr_data;
          if (push && !pop) skid_data <= wr_data;
        end
        FULL:    if (pop) rd_data <= skid_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED parity checker: forwards payload plus error flag one cycle after accept through a skid buffer
// (enc_ready low only while both slots hold words); error counter/sticky update regardless of stalls.
module ecc_sed_decoder
  import ecc_sed_pkg::*;
#(
  parameter int DATA_WIDTH = SED_DATA_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_sed_decoder_if.slave     bus,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 err_clear
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                word_err;
  logic                accept;
  logic                err_accept;
  logic [DATA_WIDTH:0] out_word;

  assign word_err   = sed_parity(64'(bus.enc_codeword));
  assign accept     = bus.enc_valid && bus.enc_ready;
  assign err_accept = accept && word_err;

  ecc_sed_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (bus.enc_valid),
    .wr_ready (bus.enc_ready),
    .wr_data  ({word_err, bus.enc_codeword[DATA_WIDTH-1:0]}),
    .rd_valid (bus.dec_valid),
    .rd_ready (bus.dec_ready),
    .rd_data  (out_word)
  );

  assign bus.dec_error = out_word[DATA_WIDTH];
  assign bus.dec_data  = out_word[DATA_WIDTH-1:0];

  // A clear coinciding with a new error restarts the count at that error rather than dropping it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (err_accept) begin
      err_sticky <= 1'b1;
      if (err_clear)               err_count <= CNT_WIDTH'(1);
      else if (err_count != CNT_MAX) err_count <= err_count + CNT_WIDTH'(1);
    end else if (err_clear) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end
  end

endmodule
